spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 21 ++
 rtl/sync_edge.sv | 34 +++
 rtl/spi_slave.sv | 200 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: FSM state encoding, idle fill byte and
// the SPI mode (CPOL/CPHA) the shift logic is built around.
package spi_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_SHIFT = 1'b1;

   localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;

   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   function automatic logic [7:0] reload_byte(input logic       full,
                                              input logic [7:0] hold,
                                              input logic [7:0] idle_byte);
      return full ? hold : idle_byte;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with one-cycle rise/fall pulses on the synchronized
// level. Reset loads the line's idle level so no edge is seen on release.
module sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= (sync_q << 1) | STAGES'(d_i);
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  =  level_o & ~prev_q;
   assign fall_o  = ~level_o &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave with tx holding register and rx valid/ready output.
// Define SPI_SLAVE_ERR_EN to add sticky overrun/underrun flags and err_clr.
module spi_slave
   import spi_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sck,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy
`ifdef SPI_SLAVE_ERR_EN
   ,
   input  logic       err_clr,
   output logic       overrun,
   output logic       underrun
`endif
);

   localparam int FILL_W = $clog2(SYNC_STAGES + 1);

   logic sck_level, sck_rise, sck_fall;
   logic cs_level, cs_rise, cs_fall;
   logic sample_edge, shift_edge;
   logic mosi_s;

   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [FILL_W-1:0]      fill_q;
   logic                   fill_done, armed_q;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [6:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_byte;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       load, byte_done;

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sck_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (sck),
      .level_o(sck_level),
      .rise_o (sck_rise),
      .fall_o (sck_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (cs_n),
      .level_o(cs_level),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   assign sample_edge = (SPI_CPHA == 1'b0) ? sck_rise : sck_fall;
   assign shift_edge  = (SPI_CPHA == 1'b0) ? sck_fall : sck_rise;
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign fill_done   = (fill_q == FILL_W'(SYNC_STAGES));

   // A cs_n held low across reset release looks like a fall once the
   // synchronizer flushes; only arm after a genuinely deselected bus is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_sync_q <= '0;
         fill_q      <= '0;
         armed_q     <= 1'b0;
      end else begin
         mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
         if (!fill_done) fill_q <= fill_q + FILL_W'(1);
         armed_q <= armed_q | (fill_done & cs_level & (sck_level == SPI_CPOL));
      end
   end

   assign rx_byte = {rx_shift_q, mosi_s};

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      load        = 1'b0;
      byte_done   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall && armed_q) begin
               state_d    = ST_SHIFT;
               load       = 1'b1;
               cnt_d      = 3'd0;
               rx_shift_d = '0;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               state_d    = ST_IDLE;
               cnt_d      = 3'd0;
               rx_shift_d = '0;
               tx_shift_d = IDLE_BYTE;
            end else if (sample_edge) begin
               rx_shift_d = rx_byte[6:0];
               cnt_d      = cnt_q + 3'd1;
               byte_done  = (cnt_q == 3'd7);
            end else if (shift_edge) begin
               if (cnt_q == 3'd0) load = 1'b1;
               else               tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A reload owns the holding register that cycle; a coincident write is not taken.
      if (load) begin
         tx_shift_d  = reload_byte(hold_full_q, hold_q, IDLE_BYTE);
         hold_full_d = 1'b0;
      end else if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      if (byte_done && (!rx_valid_q || rx_ready)) begin
         rx_data_d  = rx_byte;
         rx_valid_d = 1'b1;
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         rx_shift_q  <= '0;
         tx_shift_q  <= IDLE_BYTE;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
      end
   end

   assign busy     = (state_q == ST_SHIFT);
   assign miso_oe  = busy;
   assign miso     = miso_oe ? tx_shift_q[7] : 1'b1;
   assign tx_ready = ~hold_full_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_ERR_EN
   logic overrun_q, underrun_q;
   logic overrun_set, underrun_set;

   assign overrun_set  = byte_done & rx_valid_q & ~rx_ready;
   assign underrun_set = load & ~hold_full_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         overrun_q  <= overrun_set  | (overrun_q  & ~err_clr);
         underrun_q <= underrun_set | (underrun_q & ~err_clr);
      end
   end

   assign overrun  = overrun_q;
   assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a table of single-byte transfers plus
// hand-written sequences for latency, burst, overrun, abort and reset.
module tb_spi_slave;

   localparam int SYNC_STAGES = 2;

   logic       clk = 1'b0;
   logic       rst_n, sck, cs_n, mosi;
   logic       miso, miso_oe, busy;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
`ifdef SPI_SLAVE_ERR_EN
   logic       err_clr, overrun, underrun;
`endif

   spi_slave #(.SYNC_STAGES(SYNC_STAGES), .IDLE_BYTE(8'hFF)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sck     (sck),
      .cs_n    (cs_n),
      .mosi    (mosi),
      .miso    (miso),
      .miso_oe (miso_oe),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .busy    (busy)
`ifdef SPI_SLAVE_ERR_EN
      ,
      .err_clr (err_clr),
      .overrun (overrun),
      .underrun(underrun)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic preload(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      wait_clks(1);
      tx_valid = 1'b0;
   endtask

   task automatic accept_rx();
      rx_ready = 1'b1;
      wait_clks(1);
      rx_ready = 1'b0;
   endtask

   task automatic clear_errs();
`ifdef SPI_SLAVE_ERR_EN
      err_clr = 1'b1;
      wait_clks(1);
      err_clr = 1'b0;
`endif
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      wait_clks(SYNC_STAGES + 4);
   endtask

   task automatic cs_end();
      wait_clks(4);
      cs_n = 1'b1;
      wait_clks(SYNC_STAGES + 4);
   endtask

   // SCK = clk/8; mosi changes with the falling edge, miso sampled at the rising edge.
   task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = b[i];
         wait_clks(4);
         r[i] = miso;
         sck  = 1'b1;
         wait_clks(4);
         sck  = 1'b0;
      end
   endtask

   typedef struct {
      logic [7:0] tx;
      logic       preload;
      logic [7:0] mosi_b;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t       vecs[4];
   logic [7:0] got;
   logic [7:0] m_got[3];
   logic [7:0] burst_mosi[3];
   logic [7:0] rxq[$];
   logic       burst_done;
   int         feed_timeouts;
   int         t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'h5A, 1'b1, 8'hC3, 8'h5A, 8'hC3};
      vecs[1] = '{8'h00, 1'b0, 8'h00, 8'hFF, 8'h00};
      vecs[2] = '{8'h81, 1'b1, 8'h7E, 8'h81, 8'h7E};
      vecs[3] = '{8'hE7, 1'b1, 8'hFF, 8'hE7, 8'hFF};
      burst_mosi[0] = 8'hAA;
      burst_mosi[1] = 8'h55;
      burst_mosi[2] = 8'hC3;

      rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
`ifdef SPI_SLAVE_ERR_EN
      err_clr = 1'b0;
`endif
      wait_clks(2);
      check("rst_miso", miso, 1);
      check("rst_miso_oe", miso_oe, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      wait_clks(SYNC_STAGES + 4);

      // Table of single-byte transfers.
      for (int v = 0; v < 4; v++) begin
         clear_errs();
         if (vecs[v].preload) begin
            preload(vecs[v].tx);
            check($sformatf("v%0d_tx_ready_full", v), tx_ready, 0);
         end
         cs_begin();
         check($sformatf("v%0d_busy", v), busy, 1);
         check($sformatf("v%0d_miso_oe", v), miso_oe, 1);
`ifdef SPI_SLAVE_ERR_EN
         check($sformatf("v%0d_underrun", v), underrun, !vecs[v].preload);
`endif
         send_bits(vecs[v].mosi_b, 8, got);
         cs_end();
         check($sformatf("v%0d_miso_byte", v), got, vecs[v].exp_miso);
         check($sformatf("v%0d_rx_valid", v), rx_valid, 1);
         check($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
         check($sformatf("v%0d_idle_miso", v), miso, 1);
         accept_rx();
         check($sformatf("v%0d_rx_accepted", v), rx_valid, 0);
      end

      // rx_valid latency: set one clk after the synchronized 8th rise.
      preload(8'hA5);
      cs_begin();
      send_bits(8'h3C, 7, got);
      mosi = 1'b0;
      wait_clks(4);
      got[0] = miso;
      sck = 1'b1;
      wait_clks(SYNC_STAGES);
      check("lat_rx_valid_early", rx_valid, 0);
      wait_clks(1);
      check("lat_rx_valid", rx_valid, 1);
      check("lat_rx_data", rx_data, 8'h3C);
      wait_clks(1);
      sck = 1'b0;
      cs_end();
      check("lat_miso_byte", got, 8'hA5);
      accept_rx();

      // Three-byte burst, tx fed on tx_ready, rx_ready held high.
      preload(8'h01);
      burst_done    = 1'b0;
      feed_timeouts = 0;
      rxq.delete();
      rx_ready = 1'b1;
      fork
         begin
            cs_begin();
            for (int k = 0; k < 3; k++) send_bits(burst_mosi[k], 8, m_got[k]);
            cs_end();
            burst_done = 1'b1;
         end
         begin
            for (int k = 2; k <= 3; k++) begin
               t = 0;
               while (!tx_ready && t < 2000) begin
                  wait_clks(1);
                  t++;
               end
               if (t >= 2000) feed_timeouts++;
               else preload(8'(k));
            end
         end
         begin
            while (!burst_done) begin
               wait_clks(1);
               if (rx_valid && rx_ready) rxq.push_back(rx_data);
            end
         end
      join
      rx_ready = 1'b0;
      check("burst_feed_timeout", feed_timeouts, 0);
      check("burst_miso0", m_got[0], 8'h01);
      check("burst_miso1", m_got[1], 8'h02);
      check("burst_miso2", m_got[2], 8'h03);
      check("burst_rx_count", rxq.size(), 3);
      for (int k = 0; k < rxq.size() && k < 3; k++)
         check($sformatf("burst_rx%0d", k), rxq[k], burst_mosi[k]);

      // Overrun: second byte dropped while rx_valid is pending.
      clear_errs();
      cs_begin();
      send_bits(8'h11, 8, got);
      send_bits(8'h22, 8, got);
      cs_end();
      check("ovr_rx_valid", rx_valid, 1);
      check("ovr_rx_data", rx_data, 8'h11);
`ifdef SPI_SLAVE_ERR_EN
      check("ovr_flag", overrun, 1);
      clear_errs();
      check("ovr_flag_cleared", overrun, 0);
`endif
      accept_rx();
      check("ovr_rx_accepted", rx_valid, 0);

      // Abort after 5 bits; holding register survives into the next selection.
      preload(8'h3E);
      cs_begin();
      preload(8'hC7);
      send_bits(8'hF0, 5, got);
      check("abort_partial_miso", got, 8'h38);
      cs_n = 1'b1;
      wait_clks(SYNC_STAGES + 4);
      check("abort_rx_valid", rx_valid, 0);
      check("abort_miso_oe", miso_oe, 0);
      check("abort_busy", busy, 0);
      check("abort_miso", miso, 1);
      check("abort_hold_kept", tx_ready, 0);
      cs_begin();
      send_bits(8'h69, 8, got);
      cs_end();
      check("abort_next_miso", got, 8'hC7);
      check("abort_next_rx_valid", rx_valid, 1);
      check("abort_next_rx_data", rx_data, 8'h69);
      accept_rx();

      // Reset mid-byte with cs_n still low.
      preload(8'h12);
      cs_begin();
      send_bits(8'hB4, 4, got);
      rst_n = 1'b0;
      #1;
      check("mrst_miso", miso, 1);
      check("mrst_miso_oe", miso_oe, 0);
      check("mrst_tx_ready", tx_ready, 1);
      check("mrst_rx_valid", rx_valid, 0);
      check("mrst_rx_data", rx_data, 8'h00);
      check("mrst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_clks(SYNC_STAGES + 6);
      check("mrst_no_spurious_shift", busy, 0);
      cs_n = 1'b1;
      wait_clks(SYNC_STAGES + 4);
      preload(8'h4D);
      cs_begin();
      send_bits(8'hB2, 8, got);
      cs_end();
      check("mrst_next_miso", got, 8'h4D);
      check("mrst_next_rx_valid", rx_valid, 1);
      check("mrst_next_rx_data", rx_data, 8'hB2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
